// File: rtl/mag_timer_pkg.sv
// mag_timer_pkg: shared state encoding, BCD digit width and BCD countdown helper for mag_timer.
package mag_timer_pkg;
  localparam int BCD_W = 4;
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_COUNT, S_PAUSE, S_DONE} state_t;
  // one-second decrement of mm:ss; seconds tens restarts at 5, other digits at 9
  function automatic logic [4*BCD_W-1:0] bcd_dec(input logic [4*BCD_W-1:0] t);
    logic [4*BCD_W-1:0] r;
    r = t;
    if (t[3:0] != 4'd0) r[3:0] = t[3:0] - 4'd1;
    else begin
      r[3:0] = 4'd9;
      if (t[7:4] != 4'd0) r[7:4] = t[7:4] - 4'd1;
      else begin
        r[7:4] = 4'd5;
        if (t[11:8] != 4'd0) r[11:8] = t[11:8] - 4'd1;
        else begin
          r[11:8] = 4'd9;
          r[15:12] = t[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/mag_timer_tick_gen.sv
// tick_gen: one-cycle tick every CLK_HZ enabled cycles; restart zeroes the partial count.
module tick_gen #(parameter int CLK_HZ = 1000) (
  input  logic clk,
  input  logic resetn,
  input  logic restart,
  input  logic en,
  output logic tick
);
  localparam int W = $clog2(CLK_HZ);
  logic [W-1:0] r_cnt;
  assign tick = en && (r_cnt == W'(CLK_HZ - 1));
  always_ff @(posedge clk)
    if (!resetn || restart) r_cnt <= '0;
    else if (en) r_cnt <= tick ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/mag_timer.sv
// mag_timer: microwave keypad countdown timer (mm:ss BCD) with pause, done and clear.
// Optional beep output for three ticks after DONE when MAG_TIMER_BEEP_EN is defined.
module mag_timer import mag_timer_pkg::*; #(parameter int CLK_HZ = 1000) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clearn,
  input  logic [BCD_W-1:0] digit,
  input  logic             digit_valid,
  input  logic             mag_on,
  output logic [BCD_W-1:0] min_tens,
  output logic [BCD_W-1:0] min_ones,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] sec_ones,
  output logic             timer_done
`ifdef MAG_TIMER_BEEP_EN
  ,
  output logic             beep
`endif
);
  state_t r_state, w_state_nxt;
  logic [4*BCD_W-1:0] r_time, w_time_nxt, w_entry, w_dec;
  logic r_done, w_accept, w_tick, w_en;
  assign {min_tens, min_ones, sec_tens, sec_ones} = r_time;
  assign timer_done = r_done;
  // every state change restarts the prescaler, so COUNT always begins with a full second
  tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk(clk), .resetn(resetn), .restart(w_state_nxt != r_state), .en(w_en), .tick(w_tick)
  );
  always_comb begin
    w_accept = digit_valid && (digit <= 4'd9) && (r_state inside {S_IDLE, S_SETUP, S_DONE});
    w_entry = {(r_state == S_DONE) ? {3*BCD_W{1'b0}} : r_time[3*BCD_W-1:0], digit};
    w_dec = bcd_dec(r_time);
    w_time_nxt = r_time;
    w_state_nxt = r_state;
    if (!clearn) begin
      w_time_nxt = '0;
      w_state_nxt = S_IDLE;
    end else if (w_accept) begin
      w_time_nxt = w_entry;
      w_state_nxt = (w_entry != '0) ? S_SETUP : S_IDLE;
    end else if (r_state == S_COUNT) begin
      w_time_nxt = w_tick ? w_dec : r_time;
      w_state_nxt = (w_tick && w_dec == '0) ? S_DONE : (mag_on ? S_COUNT : S_PAUSE);
    end else if (mag_on && r_state != S_DONE)
      w_state_nxt = (r_state == S_IDLE) ? S_DONE : S_COUNT;
  end
  always_ff @(posedge clk)
    if (!resetn) begin
      r_state <= S_IDLE;
      r_time <= '0;
      r_done <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_time <= w_time_nxt;
      r_done <= (w_state_nxt == S_DONE);
    end
`ifdef MAG_TIMER_BEEP_EN
  logic r_beep;
  logic [1:0] r_beep_ticks;
  assign beep = r_beep;
  assign w_en = (r_state == S_COUNT) || (r_state == S_DONE && r_beep);
  always_ff @(posedge clk)
    if (!resetn) begin
      r_beep <= 1'b0;
      r_beep_ticks <= '0;
    end else if (w_state_nxt == S_DONE && r_state != S_DONE) begin
      r_beep <= 1'b1;
      r_beep_ticks <= '0;
    end else if (!clearn || w_accept) r_beep <= 1'b0;
    else if (r_beep && w_tick) begin
      r_beep_ticks <= r_beep_ticks + 2'd1;
      r_beep <= (r_beep_ticks != 2'd2);
    end
`else
  assign w_en = (r_state == S_COUNT);
`endif
endmodule

// File: tb/tb_mag_timer.sv
// tb_mag_timer: directed scenarios plus random stimulus against a minutes/seconds reference model.
module tb_mag_timer;
  localparam int HZ = 4;
  localparam int ST_IDLE = 0, ST_SETUP = 1, ST_COUNT = 2, ST_PAUSE = 3, ST_DONE = 4;
  logic clk = 1'b0;
  logic resetn, clearn, digit_valid, mag_on, timer_done;
  logic [3:0] digit, min_tens, min_ones, sec_tens, sec_ones;
  int n_chk = 0, n_fail = 0;
  int m_st = ST_IDLE, m_v = 0, m_ph = 0, m_beep = 0;
`ifdef MAG_TIMER_BEEP_EN
  logic beep;
`endif
  always #5 clk = ~clk;
  mag_timer #(.CLK_HZ(HZ)) dut (
    .clk(clk), .resetn(resetn), .clearn(clearn), .digit(digit), .digit_valid(digit_valid),
    .mag_on(mag_on), .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens),
    .sec_ones(sec_ones), .timer_done(timer_done)
`ifdef MAG_TIMER_BEEP_EN
    , .beep(beep)
`endif
  );
  // model: time kept as a 4-digit decimal number mmss; seconds field may exceed 59 after entry
  always @(posedge clk) begin
    int nv, ns;
    bit acc, tk;
    if (!resetn) begin
      m_st = ST_IDLE; m_v = 0; m_ph = 0; m_beep = 0;
    end else begin
      acc = digit_valid && digit <= 9 && (m_st == ST_IDLE || m_st == ST_SETUP || m_st == ST_DONE);
      tk = (m_st == ST_COUNT) && (m_ph == HZ - 1);
      nv = m_v; ns = m_st;
      if (!clearn) begin
        nv = 0; ns = ST_IDLE;
      end else if (acc) begin
        nv = ((m_st == ST_DONE ? 0 : m_v) * 10 + int'(digit)) % 10000;
        ns = (nv != 0) ? ST_SETUP : ST_IDLE;
      end else if (m_st == ST_COUNT) begin
        if (tk) nv = (m_v % 100 > 0) ? m_v - 1 : (m_v / 100 - 1) * 100 + 59;
        ns = (tk && nv == 0) ? ST_DONE : (mag_on ? ST_COUNT : ST_PAUSE);
      end else if (mag_on && m_st == ST_IDLE) ns = ST_DONE;
      else if (mag_on && (m_st == ST_SETUP || m_st == ST_PAUSE)) ns = ST_COUNT;
      m_ph = (ns != m_st) ? 0 : (m_st == ST_COUNT ? (m_ph + 1) % HZ : m_ph);
      if (ns == ST_DONE && m_st != ST_DONE) m_beep = 3 * HZ;
      else if (ns != ST_DONE || acc) m_beep = 0;
      else if (m_beep > 0) m_beep--;
      m_st = ns; m_v = nv;
    end
  end
  function automatic logic [15:0] disp();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction
  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
    chk("model_time", disp(), to_bcd(m_v));
    chk("model_done", 16'(timer_done), 16'(m_st == ST_DONE));
`ifdef MAG_TIMER_BEEP_EN
    chk("model_beep", 16'(beep), 16'(m_beep > 0));
`endif
  endtask
  task automatic key(input logic [3:0] d);
    digit = d; digit_valid = 1'b1;
    cyc();
    digit_valid = 1'b0;
  endtask
  task automatic clr();
    clearn = 1'b0; mag_on = 1'b0;
    cyc();
    clearn = 1'b1;
  endtask
  initial begin
    resetn = 1'b0; clearn = 1'b1; digit = 4'd0; digit_valid = 1'b0; mag_on = 1'b0;
    repeat (2) cyc();
    chk("reset_time", disp(), 16'h0000);
    chk("reset_done", 16'(timer_done), 16'h0);
    resetn = 1'b1;
    key(1); chk("entry_1", disp(), 16'h0001);
    key(3); chk("entry_13", disp(), 16'h0013);
    key(0); chk("entry_130", disp(), 16'h0130);
    mag_on = 1'b1;
    cyc(); chk("count_entry", disp(), 16'h0130);
    repeat (3) cyc(); chk("before_tick1", disp(), 16'h0130);
    cyc(); chk("tick1", disp(), 16'h0129);
    repeat (30 * HZ) cyc(); chk("tick31", disp(), 16'h0059);
    clr(); chk("clear_a", disp(), 16'h0000);
    key(5); mag_on = 1'b1;
    repeat (20) cyc();
    chk("tick4_of5", disp(), 16'h0001); chk("not_done_yet", 16'(timer_done), 16'h0);
    cyc();
    chk("tick5_time", disp(), 16'h0000); chk("tick5_done", 16'(timer_done), 16'h1);
    clr(); chk("clear_done", 16'(timer_done), 16'h0);
    key(4); key(2); chk("entry_42", disp(), 16'h0042);
    mag_on = 1'b1;
    repeat (3) cyc();
    mag_on = 1'b0;
    repeat (10) cyc(); chk("pause_hold", disp(), 16'h0042);
    mag_on = 1'b1;
    repeat (4) cyc(); chk("resume_no_tick", disp(), 16'h0042);
    cyc(); chk("resume_tick", disp(), 16'h0041);
    clr();
    chk("idle_done_low", 16'(timer_done), 16'h0);
    mag_on = 1'b1;
    cyc(); chk("zero_start_done", 16'(timer_done), 16'h1);
`ifdef MAG_TIMER_BEEP_EN
    chk("beep_start", 16'(beep), 16'h1);
    repeat (11) cyc(); chk("beep_last", 16'(beep), 16'h1);
    cyc(); chk("beep_end", 16'(beep), 16'h0);
`else
    repeat (12) cyc();
`endif
    chk("done_ignores_mag", 16'(timer_done), 16'h1);
    mag_on = 1'b0;
    key(7); chk("done_entry", disp(), 16'h0007);
    clr();
    key(3); mag_on = 1'b1;
    repeat (4) cyc();
    clearn = 1'b0; digit = 4'd7; digit_valid = 1'b1;
    cyc(); chk("clear_priority", disp(), 16'h0000);
    clearn = 1'b1; digit_valid = 1'b0; mag_on = 1'b0;
    cyc(); chk("clear_idle", disp(), 16'h0000);
    key(12); chk("digit12_ignored", disp(), 16'h0000);
    key(1); key(0); key(0); key(0); mag_on = 1'b1;
    repeat (5) cyc(); chk("borrow_1000", disp(), 16'h0959);
    clr();
    key(1); key(7); key(5); mag_on = 1'b1;
    repeat (5) cyc(); chk("sec_tens_7", disp(), 16'h0174);
    clr();
    key(9); key(9); mag_on = 1'b1;
    repeat (7) cyc(); chk("pre_reset", disp(), 16'h0098);
    resetn = 1'b0;
    cyc(); chk("mid_reset_time", disp(), 16'h0000);
    chk("mid_reset_done", 16'(timer_done), 16'h0);
    resetn = 1'b1; mag_on = 1'b0;
    repeat (20) cyc();
    for (int i = 0; i < 4000; i++) begin
      resetn = ($urandom_range(0, 299) != 0);
      clearn = ($urandom_range(0, 79) != 0);
      digit_valid = ($urandom_range(0, 5) == 0);
      digit = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) mag_on = ~mag_on;
      cyc();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mag_timer.md
MAG_TIMER -- requirements
Module: mag_timer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 1000, clk cycles per one-second tick (minimum 2).
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port resetn, input, 1, reset that is synchronous and active-low.
REQ-004 SHALL have port clearn, input, 1, active-low keypad clear.
REQ-005 SHALL have port digit, input, 4, BCD keypad digit.
REQ-006 SHALL have port digit_valid, input, 1, one-cycle strobe qualifying digit.
REQ-007 SHALL have port mag_on, input, 1, magnetron latch state, high while cooking.
REQ-008 SHALL have ports min_tens, min_ones, sec_tens, sec_ones, output, 4 each, registered BCD remaining time.
REQ-009 SHALL have port timer_done, output, 1, registered level, high in DONE.

Function
REQ-010 SHALL implement states IDLE (time 0000), SETUP (time nonzero, not counting), COUNT, PAUSE and DONE.
REQ-011 SHALL accept a digit only on digit_valid with digit<=9 in IDLE, SETUP or DONE; digits 10-15 and entries in COUNT/PAUSE are ignored.
REQ-012 SHALL shift an accepted digit in: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=digit. An entry in DONE first zeroes the time, so the result is 000d.
REQ-013 SHALL move to SETUP after an accepted entry that makes the time nonzero, and otherwise remain in or go to IDLE.
REQ-014 SHALL go SETUP->COUNT and PAUSE->COUNT when mag_on=1, and COUNT->PAUSE when mag_on=0.
REQ-015 SHALL restart the tick prescaler on every entry into COUNT, so that the first decrement occurs exactly CLK_HZ cycles after the transition cycle.
REQ-016 SHALL, on each tick in COUNT, decrement the time by one second with BCD borrow: sec_ones 0->9 borrows from sec_tens, sec_tens 0->5 borrows from min_ones, and min_ones 0->9 borrows from min_tens.
REQ-017 SHALL accept sec_tens values 6-9 from entry and count them down normally, e.g. 0175 -> 0174.
REQ-018 SHALL go COUNT->DONE on the tick that yields 0000, with timer_done=1 in the same cycle as the 0000 display.
REQ-019 SHALL go from IDLE with mag_on=1 to DONE on the next cycle, so that a zero-time start is terminated.
REQ-020 SHALL go from DONE to IDLE on clearn=0, and from DONE to SETUP on a nonzero entry; mag_on has no effect in DONE.
REQ-021 SHALL, on clearn=0 in any state, zero the time and go to IDLE next cycle, with priority over digit_valid, tick and mag_on.
REQ-022 SHALL hold the time unchanged in PAUSE, and SHALL discard the partial prescaler count.

Reset
REQ-023 SHALL, with resetn=0 at a clk edge, set state IDLE, all BCD outputs 0, timer_done 0, prescaler 0; resetn has priority over clearn.
REQ-024 SHALL, on reset in the middle of COUNT, abandon the count with no timer_done pulse.

Configuration
REQ-025 SHALL, with MAG_TIMER_BEEP_EN defined, add output beep (1 bit, reset 0), high from entry into DONE for 3 ticks, cleared early by clearn=0 or a new entry.
REQ-026 SHALL, without MAG_TIMER_BEEP_EN, have no beep port and no beep counter logic.

Structure
REQ-027 SHALL place the state encoding enum and the BCD digit width constant in package mag_timer_pkg.
REQ-028 SHALL implement the prescaler as sub-module tick_gen (inputs clk, resetn, restart, en; output tick, a one-cycle pulse every CLK_HZ enabled cycles).

Verification (CLK_HZ=4)
REQ-029 SHALL verify: entry 1,3,0 then mag_on=1 -> display 0130 in SETUP, 0129 exactly 4 cycles after COUNT entry, 0059 after 31 ticks.
REQ-030 SHALL verify: entry 5, mag_on=1 for 5 ticks -> 0000 and timer_done=1 on tick 5; then clearn=0 -> IDLE and timer_done=0 next cycle.
REQ-031 SHALL verify: mag_on dropped for 10 cycles in COUNT at 0042 -> display holds 0042; on resume, the next decrement occurs 4 cycles later.
REQ-032 SHALL verify: mag_on=1 in IDLE -> DONE with timer_done=1 on the second cycle.
REQ-033 SHALL verify: clearn=0 together with digit_valid and a tick in COUNT -> 0000 and IDLE; digit 12 strobed in IDLE -> no change.
REQ-034 SHALL verify: resetn=0 in the middle of COUNT -> all outputs 0 next cycle; with MAG_TIMER_BEEP_EN, beep stays high exactly 12 cycles after DONE.
